fetch_aligner: RTL and testbench

- Sits between the instruction-memory response and the decompresser/decode stage.
- Takes 32-bit word-aligned fetch words and emits one instruction per handshake: either a 16-bit compressed instruction (zero-extended) or a full 32-bit instruction.
- Stitches 32-bit instructions that straddle a word boundary, tracks the instruction PC, and handles jumps to halfword-aligned targets.

---
 rtl/RS5_pkg.sv | 17 +
 rtl/fetch_aligner.sv | 146 ++++++++++++++
 tb/tb_fetch_aligner.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/RS5_pkg.sv
// Shared types and encodings for the instruction fetch aligner.
package RS5_pkg;

    typedef enum logic [1:0] {
        ALIGNER_ALIGNED = 2'd0,
        ALIGNER_HALF    = 2'd1,
        ALIGNER_SKIP    = 2'd2
    } aligner_state_e;

    localparam logic [1:0] OPCODE_32B = 2'b11;

    // A parcel is compressed unless its two low bits mark a 32-bit opcode.
    function automatic logic is_compressed(input logic [1:0] low_bits);
        return low_bits != OPCODE_32B;
    endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Splits word-aligned fetch words into 16/32-bit instructions, stitching across words.
// Optional macro ALIGNER_STITCH_CNT_EN adds stitch_count_o (cross-word 32-bit instruction count).
module fetch_aligner
    import RS5_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] instr_o,
    output logic        compressed_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
`ifdef ALIGNER_STITCH_CNT_EN
    output logic [31:0] stitch_count_o,
`endif
    input  logic        instr_ready_i
);

    aligner_state_e state_reg, state_next;
    logic [15:0]    residue_reg, residue_next;
    logic [31:0]    pc_reg, pc_next;
    logic           stitch_xfer;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ALIGNER_ALIGNED;
            residue_reg <= 16'h0000;
            pc_reg      <= START_ADDR;
        end else begin
            state_reg   <= state_next;
            residue_reg <= residue_next;
            pc_reg      <= pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        residue_next  = residue_reg;
        pc_next       = pc_reg;
        instr_valid_o = 1'b0;
        word_ready_o  = 1'b0;
        instr_o       = 32'h0000_0000;
        stitch_xfer   = 1'b0;

        if (jump_i) begin
            // Redirect wins: drop whatever word is on the bus this cycle.
            word_ready_o = word_valid_i;
            pc_next      = jump_target_i & 32'hFFFF_FFFE;
            residue_next = 16'h0000;
            state_next   = jump_target_i[1] ? ALIGNER_SKIP : ALIGNER_ALIGNED;
        end else begin
            case (state_reg)
                ALIGNER_ALIGNED: begin
                    if (word_valid_i) begin
                        instr_valid_o = 1'b1;
                        word_ready_o  = instr_ready_i;
                        if (is_compressed(word_i[1:0])) begin
                            instr_o = {16'h0000, word_i[15:0]};
                            if (instr_ready_i) begin
                                residue_next = word_i[31:16];
                                pc_next      = pc_reg + 32'd2;
                                state_next   = ALIGNER_HALF;
                            end
                        end else begin
                            instr_o = word_i;
                            if (instr_ready_i) begin
                                pc_next = pc_reg + 32'd4;
                            end
                        end
                    end
                end

                ALIGNER_HALF: begin
                    if (is_compressed(residue_reg[1:0])) begin
                        // Residue alone is a full instruction; the bus word is left untouched.
                        instr_valid_o = 1'b1;
                        instr_o       = {16'h0000, residue_reg};
                        if (instr_ready_i) begin
                            pc_next    = pc_reg + 32'd2;
                            state_next = ALIGNER_ALIGNED;
                        end
                    end else if (word_valid_i) begin
                        instr_valid_o = 1'b1;
                        word_ready_o  = instr_ready_i;
                        instr_o       = {word_i[15:0], residue_reg};
                        if (instr_ready_i) begin
                            residue_next = word_i[31:16];
                            pc_next      = pc_reg + 32'd4;
                            stitch_xfer  = 1'b1;
                        end
                    end
                end

                ALIGNER_SKIP: begin
                    if (word_valid_i) begin
                        if (is_compressed(word_i[17:16])) begin
                            instr_valid_o = 1'b1;
                            word_ready_o  = instr_ready_i;
                            instr_o       = {16'h0000, word_i[31:16]};
                            if (instr_ready_i) begin
                                pc_next    = pc_reg + 32'd2;
                                state_next = ALIGNER_ALIGNED;
                            end
                        end else begin
                            // Upper half starts a 32-bit instruction: absorb it without output.
                            word_ready_o = 1'b1;
                            residue_next = word_i[31:16];
                            state_next   = ALIGNER_HALF;
                        end
                    end
                end

                default: begin
                    state_next = ALIGNER_ALIGNED;
                end
            endcase
        end
    end

    assign compressed_o = instr_valid_o && is_compressed(instr_o[1:0]);
    assign pc_o         = pc_reg;

`ifdef ALIGNER_STITCH_CNT_EN
    logic [31:0] stitch_count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stitch_count_reg <= 32'h0000_0000;
        end else if (stitch_xfer) begin
            stitch_count_reg <= stitch_count_reg + 32'd1;
        end
    end

    assign stitch_count_o = stitch_count_reg;
`else
    logic unused_stitch;
    assign unused_stitch = stitch_xfer;
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed self-checking bench for fetch_aligner; one printed line per transaction.
module tb_fetch_aligner;

    logic        clk;
    logic        reset_n;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic [31:0] instr_o;
    logic        compressed_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
`ifdef ALIGNER_STITCH_CNT_EN
    logic [31:0] stitch_count_o;
`endif

    int tests_run;
    int tests_failed;

    fetch_aligner #(.START_ADDR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .word_i        (word_i),
        .word_valid_i  (word_valid_i),
        .word_ready_o  (word_ready_o),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .instr_o       (instr_o),
        .compressed_o  (compressed_o),
        .pc_o          (pc_o),
        .instr_valid_o (instr_valid_o),
`ifdef ALIGNER_STITCH_CNT_EN
        .stitch_count_o(stitch_count_o),
`endif
        .instr_ready_i (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational outputs, then clock it in.
    task automatic xfer(input string tag, input logic [31:0] word, input logic wv,
                        input logic ready, input logic exp_valid,
                        input logic [31:0] exp_instr, input logic [31:0] exp_pc,
                        input logic exp_wready);
        logic exp_comp;
        word_i        = word;
        word_valid_i  = wv;
        instr_ready_i = ready;
        jump_i        = 1'b0;
        #1;
        exp_comp = exp_valid && (exp_instr[1:0] != 2'b11);
        check_eq({tag, ".valid"},  {31'h0, instr_valid_o}, {31'h0, exp_valid});
        check_eq({tag, ".instr"},  instr_o, exp_instr);
        check_eq({tag, ".pc"},     pc_o, exp_pc);
        check_eq({tag, ".wready"}, {31'h0, word_ready_o}, {31'h0, exp_wready});
        check_eq({tag, ".comp"},   {31'h0, compressed_o}, {31'h0, exp_comp});
        $display("[TB] %-10s word=%h wv=%0b rdy=%0b -> valid=%0b instr=%h pc=%h wready=%0b",
                 tag, word, wv, ready, instr_valid_o, instr_o, pc_o, word_ready_o);
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input string tag, input logic [31:0] target,
                           input logic [31:0] word, input logic wv);
        jump_i        = 1'b1;
        jump_target_i = target;
        word_i        = word;
        word_valid_i  = wv;
        instr_ready_i = 1'b1;
        #1;
        check_eq({tag, ".valid"},  {31'h0, instr_valid_o}, 32'h0);
        check_eq({tag, ".wready"}, {31'h0, word_ready_o}, {31'h0, wv});
        $display("[TB] %-10s target=%h word=%h wv=%0b -> valid=%0b wready=%0b",
                 tag, target, word, wv, instr_valid_o, word_ready_o);
        @(posedge clk);
        #1;
        jump_i = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n      = 1'b0;
        word_valid_i = 1'b0;
        jump_i       = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset_n       = 1'b0;
        word_i        = 32'h0;
        word_valid_i  = 1'b0;
        jump_i        = 1'b0;
        jump_target_i = 32'h0;
        instr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state, idle bus
        xfer("reset", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Two compressed then one full instruction
        xfer("c0",  32'h4501_4581, 1'b1, 1'b1, 1'b1, 32'h0000_4581, 32'h0, 1'b1);
        xfer("c1",  32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_4501, 32'h2, 1'b0);
        xfer("w32", 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h4, 1'b1);
        xfer("idle0", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h8, 1'b0);

        // Straddling 32-bit instruction
        pulse_reset();
        xfer("s0", 32'h0513_4581, 1'b1, 1'b1, 1'b1, 32'h0000_4581, 32'h0, 1'b1);
        xfer("s1", 32'h4505_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0513, 32'h2, 1'b1);
        xfer("s2", 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_4505, 32'h6, 1'b0);
`ifdef ALIGNER_STITCH_CNT_EN
        check_eq("stitch1", stitch_count_o, 32'd1);
`endif

        // Jump to halfword target, compressed upper half; SKIP hold
        do_jump("jmp102", 32'h0000_0102, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 5; i++)
            xfer("skip_hold", 32'h4585_FFFF, 1'b1, 1'b0, 1'b1, 32'h0000_4585, 32'h102, 1'b0);
        xfer("skip_c", 32'h4585_FFFF, 1'b1, 1'b1, 1'b1, 32'h0000_4585, 32'h102, 1'b1);
        xfer("post_skip", 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h104, 1'b1);

        // Jump to halfword target, upper half begins a 32-bit instruction
        do_jump("jmp202", 32'h0000_0202, 32'h0, 1'b0);
        xfer("skip_st", 32'h0093_0001, 1'b1, 1'b0, 1'b0, 32'h0, 32'h202, 1'b1);
        for (int i = 0; i < 5; i++)
            xfer("half_hold", 32'hABCD_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0093, 32'h202, 1'b0);
        xfer("half_st", 32'hABCD_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0093, 32'h202, 1'b1);
`ifdef ALIGNER_STITCH_CNT_EN
        check_eq("stitch2", stitch_count_o, 32'd2);
`endif
        for (int i = 0; i < 5; i++)
            xfer("halfc_hold", 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 32'h206, 1'b0);
        xfer("half_c", 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 32'h206, 1'b0);

        // ALIGNED hold
        for (int i = 0; i < 5; i++)
            xfer("al_hold", 32'h0000_0013, 1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h208, 1'b0);
        xfer("al_go", 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h208, 1'b1);

        // Reset mid-stitch discards the residue
        xfer("r0", 32'h0513_4581, 1'b1, 1'b1, 1'b1, 32'h0000_4581, 32'h20C, 1'b1);
        pulse_reset();
        xfer("rst_idle", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef ALIGNER_STITCH_CNT_EN
        check_eq("stitch_rst", stitch_count_o, 32'd0);
`endif
        xfer("rst_w", 32'h0000_0013, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h0, 1'b1);

        // PC wrap; bit0 of target ignored
        do_jump("jmpwrap", 32'hFFFF_FFFD, 32'h0, 1'b0);
        xfer("wrap0", 32'h4501_4581, 1'b1, 1'b1, 1'b1, 32'h0000_4581, 32'hFFFF_FFFC, 1'b1);
        xfer("wrap1", 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_4501, 32'hFFFF_FFFE, 1'b0);
        xfer("wrap2", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
